// File: rtl/sdf_r22_stage.sv
// sdf_r22_stage: radix-2^2 single-path delay-feedback butterfly stage (BF2I, or BF2II with -j rotation)
// Ports: clk; rst_n (synchronous, active-low); enable_in/in_re/in_im input stream;
//        enable_out/out_re/out_im registered output stream (values hold while enable_out is low).
// Build option: define SDF_SCALE_EN to halve every output (arithmetic shift right 1) and
//        narrow the outputs to WIDTH bits; otherwise outputs are WIDTH+1 bits, unscaled.
module sdf_r22_stage #(
    parameter int WIDTH = 8,
    parameter int DELAY = 32,
    parameter int MODE  = 0,
`ifdef SDF_SCALE_EN
    localparam int OW = WIDTH
`else
    localparam int OW = WIDTH + 1
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             enable_out,
    output logic [OW-1:0]    out_re,
    output logic [OW-1:0]    out_im
);
    localparam int LG = $clog2(DELAY);
    // cnt width equals log2 of the frame period, so it wraps at P on its own
    localparam int CW = LG + (MODE == 1 ? 2 : 1);
    localparam int AW = LG > 0 ? LG : 1;
    localparam int XW = WIDTH + 1;
    localparam int SH = XW - OW;
    localparam int unsigned ROT = 3 * DELAY;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CW-1:0] cnt;
    logic pending, draining;
    logic [2*XW-1:0] mem [DELAY];
    logic [AW-1:0] idx;
    logic phase, rot, accept, drain_step, last, fire;
    logic [WIDTH-1:0] neg_re;
    logic signed [XW-1:0] x_re, x_im, h_re, h_im, sum_re, sum_im, dif_re, dif_im, res_re, res_im;
    logic [2*XW-1:0] push;
    logic [OW-1:0] o_re, o_im;

    // The delay line is a circular buffer: the slot read this cycle is rewritten this cycle
    // and comes back round exactly D shifts later, so cnt mod D is the only pointer needed.
    assign idx = LG > 0 ? cnt[AW-1:0] : '0;
    assign phase = cnt[LG];
    assign rot = (MODE == 1) && (32'(cnt) >= ROT);
    // -j rotation: negating the most negative value would wrap, so clamp it to the maximum
    assign neg_re = (in_re == MIN) ? ~MIN : -in_re;
    assign x_re = rot ? {in_im[WIDTH-1], in_im} : {in_re[WIDTH-1], in_re};
    assign x_im = rot ? {neg_re[WIDTH-1], neg_re} : {in_im[WIDTH-1], in_im};
    assign {h_re, h_im} = mem[idx];
    assign sum_re = h_re + x_re;
    assign sum_im = h_im + x_im;
    assign dif_re = h_re - x_re;
    assign dif_im = h_im - x_im;
    assign accept = enable_in;
    // a drain starts when the input idles on a frame boundary with a frame still in the line
    assign drain_step = !enable_in && (draining || (cnt == '0 && pending));
    assign last = cnt == CW'(DELAY - 1);
    assign fire = (accept && (phase || pending)) || drain_step;
    assign res_re = (accept && phase) ? sum_re : h_re;
    assign res_im = (accept && phase) ? sum_im : h_im;
    assign o_re = OW'(res_re >>> SH);
    assign o_im = OW'(res_im >>> SH);
    assign push = !accept ? '0 : phase ? {dif_re, dif_im} : {x_re, x_im};

    always_ff @(posedge clk) begin
        if (rst_n && (accept || drain_step)) mem[idx] <= push;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            pending    <= 1'b0;
            draining   <= 1'b0;
            enable_out <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
        end else begin
            enable_out <= fire;
            if (fire) begin
                out_re <= o_re;
                out_im <= o_im;
            end
            if (accept) begin
                cnt      <= cnt + 1'b1;
                pending  <= pending | phase;
                // a sample arriving mid-drain lets the drain run out at cnt == D
                draining <= draining && !last;
            end else if (drain_step) begin
                cnt      <= last ? '0 : cnt + 1'b1;
                pending  <= !last;
                draining <= !last;
            end
        end
    end
endmodule

// File: tb/tb_sdf_r22_stage.sv
// tb_sdf_r22_stage: randomized and directed bench for sdf_r22_stage against a queue-based model
module tb_sdf_r22_stage;
    localparam int W = 8;
`ifdef SDF_SCALE_EN
    localparam int OW = W;
    localparam bit SC = 1'b1;
`else
    localparam int OW = W + 1;
    localparam bit SC = 1'b0;
`endif
    localparam int DA = 4;
    localparam int DB = 2;
    localparam int MINV = -(1 << (W - 1));
    localparam int MAXV = (1 << (W - 1)) - 1;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [W-1:0] in_re = '0, in_im = '0;
    logic en_a, en_b;
    logic [OW-1:0] a_re, a_im, b_re, b_im;
    int checks = 0, failures = 0;
    int m_cnt[2], m_pend[2], m_drn[2], m_v[2], m_re[2], m_im[2];
    int q_re[2][8], q_im[2][8];
    int va_re[$], va_im[$], vb_re[$], vb_im[$];

    always #5 clk = ~clk;

    sdf_r22_stage #(.WIDTH(W), .DELAY(DA), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable_in(en), .in_re(in_re), .in_im(in_im),
        .enable_out(en_a), .out_re(a_re), .out_im(a_im));
    sdf_r22_stage #(.WIDTH(W), .DELAY(DB), .MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable_in(en), .in_re(in_re), .in_im(in_im),
        .enable_out(en_b), .out_re(b_re), .out_im(b_im));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int sc(input int v);
        return SC ? (v >>> 1) : v;
    endfunction

    // Spec-level model: a FIFO of D complex entries, a sample counter and the pending/drain flags.
    task automatic model(input int k);
        int d, p, xr, xi, hr, hi, pr, pi, r, i, nr;
        d = k ? DB : DA;
        p = k ? 4 * DB : 2 * DA;
        m_v[k] = 0;
        if (!rst_n) begin
            m_cnt[k] = 0; m_pend[k] = 0; m_drn[k] = 0; m_re[k] = 0; m_im[k] = 0;
            return;
        end
        hr = q_re[k][0];
        hi = q_im[k][0];
        xr = $signed(in_re);
        xi = $signed(in_im);
        if (k == 1 && m_cnt[k] >= 3 * d) begin
            nr = $signed(in_re);
            xr = $signed(in_im);
            xi = (nr == MINV) ? MAXV : -nr;
        end
        if (en) begin
            if ((m_cnt[k] / d) % 2 == 1) begin
                r = hr + xr; i = hi + xi; pr = hr - xr; pi = hi - xi;
                m_v[k] = 1; m_pend[k] = 1;
            end else begin
                r = hr; i = hi; pr = xr; pi = xi;
                m_v[k] = m_pend[k];
            end
            if (m_drn[k] == 1 && m_cnt[k] == d - 1) m_drn[k] = 0;
            m_cnt[k] = (m_cnt[k] + 1) % p;
        end else if (m_drn[k] == 1 || (m_cnt[k] == 0 && m_pend[k] == 1)) begin
            r = hr; i = hi; pr = 0; pi = 0;
            m_v[k] = 1; m_drn[k] = 1;
            m_cnt[k]++;
            if (m_cnt[k] == d) begin
                m_cnt[k] = 0; m_pend[k] = 0; m_drn[k] = 0;
            end
        end else return;
        for (int j = 0; j < d - 1; j++) begin
            q_re[k][j] = q_re[k][j+1];
            q_im[k][j] = q_im[k][j+1];
        end
        q_re[k][d-1] = pr;
        q_im[k][d-1] = pi;
        if (m_v[k] == 1) begin
            m_re[k] = sc(r);
            m_im[k] = sc(i);
        end
    endtask

    task automatic step(input logic r, input logic e, input int re, input int im);
        rst_n = r;
        en = e;
        in_re = re[W-1:0];
        in_im = im[W-1:0];
        @(posedge clk);
        #1;
        model(0);
        model(1);
        check("A.valid", int'(en_a), m_v[0]);
        check("A.re", int'($signed(a_re)), m_re[0]);
        check("A.im", int'($signed(a_im)), m_im[0]);
        check("B.valid", int'(en_b), m_v[1]);
        check("B.re", int'($signed(b_re)), m_re[1]);
        check("B.im", int'($signed(b_im)), m_im[1]);
        if (en_a) begin va_re.push_back(int'($signed(a_re))); va_im.push_back(int'($signed(a_im))); end
        if (en_b) begin vb_re.push_back(int'($signed(b_re))); vb_im.push_back(int'($signed(b_im))); end
    endtask

    task automatic clear_seq();
        va_re.delete(); va_im.delete(); vb_re.delete(); vb_im.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
    endtask

    task automatic expect_seq(input string tag, input int gr[$], input int gi[$], input int er[$], input int ei[$]);
        check({tag, ".len"}, gr.size(), er.size());
        for (int i = 0; i < er.size() && i < gr.size(); i++) begin
            check($sformatf("%s.re[%0d]", tag, i), gr[i], sc(er[i]));
            check($sformatf("%s.im[%0d]", tag, i), gi[i], sc(ei[i]));
        end
    endtask

    function automatic int rv();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1) ? MINV : MAXV;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        int er[$], ei[$];
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 8; j++) begin q_re[k][j] = 0; q_im[k][j] = 0; end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rv(), rv());
        check("rst.A.valid", int'(en_a), 0);
        check("rst.A.re", int'($signed(a_re)), 0);
        check("rst.B.valid", int'(en_b), 0);
        check("rst.B.im", int'($signed(b_im)), 0);

        clear_seq();
        for (int n = 0; n < 8; n++) begin
            step(1'b1, 1'b1, n, n);
            if (n == DA - 1) check("first.A.none_yet", va_re.size(), 0);
            if (n == DA) check("first.A.after_D+1", va_re.size(), 1);
        end
        idle(10);
        er = '{4, 6, 8, 10, -4, -4, -4, -4};
        expect_seq("ramp.A", va_re, va_im, er, er);

        clear_seq();
        for (int n = 0; n < 8; n++) begin
            if (n % 2 == 1) begin
                step(1'b1, 1'b0, 0, 0);
                check("stall.A.gap_low", int'(en_a), 0);
            end
            step(1'b1, 1'b1, n, n);
        end
        idle(10);
        expect_seq("stall.A", va_re, va_im, er, er);

        clear_seq();
        for (int n = 0; n < 8; n++) step(1'b1, 1'b1, n < 4 ? 127 : -128, 0);
        idle(10);
        er = '{-1, -1, -1, -1, 255, 255, 255, 255};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        expect_seq("growth.A", va_re, va_im, er, ei);

        clear_seq();
        for (int n = 0; n < 8; n++) step(1'b1, 1'b1, 1, 0);
        idle(10);
        er = '{2, 2, 0, 0, 1, 1, 1, 1};
        ei = '{0, 0, 0, 0, -1, -1, 1, 1};
        expect_seq("bf2ii.B", vb_re, vb_im, er, ei);

        clear_seq();
        for (int n = 0; n < 8; n++) step(1'b1, 1'b1, n == 6 ? -128 : 0, 0);
        idle(10);
        er = '{0, 0, 0, 0, 0, 0, 0, 0};
        ei = '{0, 0, 0, 0, 127, 0, -127, 0};
        expect_seq("sat.B", vb_re, vb_im, er, ei);

        for (int n = 0; n < 5; n++) step(1'b1, 1'b1, rv(), rv());
        clear_seq();
        step(1'b0, 1'b1, rv(), rv());
        check("midrst.A.valid", int'(en_a), 0);
        check("midrst.B.valid", int'(en_b), 0);
        idle(10);
        check("midrst.A.no_drain", va_re.size(), 0);
        check("midrst.B.no_drain", vb_re.size(), 0);

        for (int f = 0; f < 40; f++) begin
            for (int n = 0; n < 8; n++) begin
                if (n > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if ($urandom_range(0, 60) == 0) step(1'b0, 1'b1, rv(), rv());
                else step(1'b1, 1'b1, rv(), rv());
            end
            if ($urandom_range(0, 2) == 0) idle(10);
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
